// File: rtl/alu_input_sequencer_if.sv
// Switch/button inputs and operand/opcode/status outputs of the ALU input sequencer.
// The DUT connects through the slave modport; the driver of the buttons uses master.
interface alu_input_sequencer_if #(
    parameter int NB_DATA      = 8,
    parameter int NB_OPCODE    = 6,
    parameter int N_PULSADORES = 4
);
    logic signed [NB_DATA-1:0]   i_switches;
    logic [N_PULSADORES-1:0]     i_pulsadores;
    logic signed [NB_DATA-1:0]   o_op_1;
    logic signed [NB_DATA-1:0]   o_op_2;
    logic [NB_OPCODE-1:0]        o_opcode;
    logic                        o_valid;
    logic                        o_error;
    logic [1:0]                  o_state;

    modport master (
        output i_switches,
        output i_pulsadores,
        input  o_op_1,
        input  o_op_2,
        input  o_opcode,
        input  o_valid,
        input  o_error,
        input  o_state
    );

    modport slave (
        input  i_switches,
        input  i_pulsadores,
        output o_op_1,
        output o_op_2,
        output o_opcode,
        output o_valid,
        output o_error,
        output o_state
    );
endinterface

// File: rtl/alu_input_sequencer.sv
// Captures ALU operand A, operand B and opcode from the switches under debounced
// pushbutton control, enforcing the A -> B -> opcode load order.
module alu_input_sequencer #(
    parameter int NB_DATA         = 8,
    parameter int NB_OPCODE       = 6,
    parameter int N_PULSADORES    = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    alu_input_sequencer_if.slave  bus
);
    localparam int NB_BTN = 4;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_A   = 2'd0,
        WAIT_B   = 2'd1,
        WAIT_OPC = 2'd2,
        DONE     = 2'd3
    } state_t;

    logic [NB_BTN-1:0] sync1_q, sync1_d;
    logic [NB_BTN-1:0] sync2_q, sync2_d;
    logic [NB_BTN-1:0] deb_q, deb_d;
    logic [NB_BTN-1:0] deb_prev_q, deb_prev_d;
    logic [CNT_W-1:0]  cnt_q [NB_BTN];
    logic [CNT_W-1:0]  cnt_d [NB_BTN];

    logic [NB_BTN-1:0] press;
    logic              multi_press;

    state_t                    state_q, state_d;
    logic signed [NB_DATA-1:0] op_1_q, op_1_d;
    logic signed [NB_DATA-1:0] op_2_q, op_2_d;
    logic [NB_OPCODE-1:0]      opcode_q, opcode_d;
    logic                      valid_q, valid_d;
    logic                      error_q, error_d;

    // The level flips only once the increment that would reach DEBOUNCE_CYCLES happens.
    always_comb begin
        sync1_d    = bus.i_pulsadores[NB_BTN-1:0];
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        for (int i = 0; i < NB_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press       = deb_q & ~deb_prev_q;
    assign multi_press = |(press & (press - 4'd1));

    always_comb begin
        state_d  = state_q;
        op_1_d   = op_1_q;
        op_2_d   = op_2_q;
        opcode_d = opcode_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        if (press != '0) begin
            if (multi_press) begin
                error_d = 1'b1;
            end else if (press[3]) begin
                state_d  = WAIT_A;
                op_1_d   = '0;
                op_2_d   = '0;
                opcode_d = '0;
            end else begin
                case (state_q)
                    WAIT_A: begin
                        if (press[0]) begin
                            op_1_d  = bus.i_switches;
                            state_d = WAIT_B;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                    WAIT_B: begin
                        if (press[1]) begin
                            op_2_d  = bus.i_switches;
                            state_d = WAIT_OPC;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                    WAIT_OPC: begin
                        if (press[2]) begin
                            opcode_d = bus.i_switches[NB_OPCODE-1:0];
                            state_d  = DONE;
                            valid_d  = 1'b1;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                    default: begin
                        // In DONE, A restarts a sequence while B/opcode are edited in place.
                        if (press[0]) begin
                            op_1_d  = bus.i_switches;
                            state_d = WAIT_B;
                        end else if (press[1]) begin
                            op_2_d  = bus.i_switches;
                            valid_d = 1'b1;
                        end else begin
                            opcode_d = bus.i_switches[NB_OPCODE-1:0];
                            valid_d  = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < NB_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            state_q  <= WAIT_A;
            op_1_q   <= '0;
            op_2_q   <= '0;
            opcode_q <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            for (int i = 0; i < NB_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q  <= state_d;
            op_1_q   <= op_1_d;
            op_2_q   <= op_2_d;
            opcode_q <= opcode_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign bus.o_op_1   = op_1_q;
    assign bus.o_op_2   = op_2_q;
    assign bus.o_opcode = opcode_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_error  = error_q;
    assign bus.o_state  = state_q;
endmodule

// File: tb/tb_alu_input_sequencer.sv
// Scoreboard bench: each press predicts its observable outcome and cycle from a
// behavioural model; a negedge monitor compares every output event it sees.
module tb_alu_input_sequencer;
    localparam int NB_DATA         = 8;
    localparam int NB_OPCODE       = 6;
    localparam int N_PULSADORES    = 4;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int LATENCY         = DEBOUNCE_CYCLES + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_input_sequencer_if #(
        .NB_DATA(NB_DATA), .NB_OPCODE(NB_OPCODE), .N_PULSADORES(N_PULSADORES)
    ) bus ();

    alu_input_sequencer #(
        .NB_DATA(NB_DATA), .NB_OPCODE(NB_OPCODE),
        .N_PULSADORES(N_PULSADORES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus(bus)
    );

    typedef struct {
        int                cycle;
        logic              valid;
        logic              error;
        logic signed [7:0] op1;
        logic signed [7:0] op2;
        logic [5:0]        opc;
        logic [1:0]        state;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    int                m_state = 0;
    logic signed [7:0] m_op1   = '0;
    logic signed [7:0] m_op2   = '0;
    logic [5:0]        m_opc   = '0;

    always @(posedge clk) cycle++;

    // Predicts what one debounced press does and when it becomes visible.
    task automatic model_press(input logic [3:0] mask, input logic signed [7:0] sw, input int rise_cycle);
        exp_t e;
        int   b;
        bit   v, er, changed;
        v = 0; er = 0; changed = 0;
        if (mask == 4'd0) return;
        if ($countones(mask) > 1) begin
            er = 1;
        end else if (mask[3]) begin
            changed = (m_op1 != 0) || (m_op2 != 0) || (m_opc != 0) || (m_state != 0);
            m_op1 = '0; m_op2 = '0; m_opc = '0; m_state = 0;
        end else begin
            b = mask[0] ? 0 : (mask[1] ? 1 : 2);
            if (m_state == b || m_state == 3) begin
                if (b == 0) m_op1 = sw;
                else if (b == 1) m_op2 = sw;
                else m_opc = sw[5:0];
                m_state = (m_state == 3 && b != 0) ? 3 : b + 1;
                v = (m_state == 3);
                changed = 1;
            end else begin
                er = 1;
            end
        end
        if (v || er || changed) begin
            e.cycle = rise_cycle + LATENCY;
            e.valid = v;
            e.error = er;
            e.op1   = m_op1;
            e.op2   = m_op2;
            e.opc   = m_opc;
            e.state = 2'(m_state);
            exp_q.push_back(e);
        end
    endtask

    logic signed [7:0] prev_op1, prev_op2;
    logic [5:0]        prev_opc;
    logic [1:0]        prev_state;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_op1 = '0; prev_op2 = '0; prev_opc = '0; prev_state = '0;
        end else begin
            if (bus.o_valid || bus.o_error || bus.o_op_1 != prev_op1 || bus.o_op_2 != prev_op2 ||
                bus.o_opcode != prev_opc || bus.o_state != prev_state) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_event cycle=%0d got v=%0b e=%0b op1=%0d op2=%0d opc=%h st=%0d required no event",
                             cycle, bus.o_valid, bus.o_error, bus.o_op_1, bus.o_op_2, bus.o_opcode, bus.o_state);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.o_valid !== e.valid || bus.o_error !== e.error || bus.o_op_1 !== e.op1 ||
                        bus.o_op_2 !== e.op2 || bus.o_opcode !== e.opc || bus.o_state !== e.state) begin
                        failures++;
                        $display("[TB] FAIL event_fields got v=%0b e=%0b op1=%0d op2=%0d opc=%h st=%0d required v=%0b e=%0b op1=%0d op2=%0d opc=%h st=%0d",
                                 bus.o_valid, bus.o_error, bus.o_op_1, bus.o_op_2, bus.o_opcode, bus.o_state,
                                 e.valid, e.error, e.op1, e.op2, e.opc, e.state);
                    end
                    checks++;
                    if (cycle != e.cycle) begin
                        failures++;
                        $display("[TB] FAIL event_latency got cycle=%0d required cycle=%0d", cycle, e.cycle);
                    end
                end
            end
            prev_op1 = bus.o_op_1; prev_op2 = bus.o_op_2;
            prev_opc = bus.o_opcode; prev_state = bus.o_state;
        end
    end

    task automatic checkOutput(input string name, input logic signed [7:0] op1, input logic signed [7:0] op2,
                               input logic [5:0] opc, input logic [1:0] st, input logic v, input logic er);
        checks++;
        if (bus.o_op_1 !== op1 || bus.o_op_2 !== op2 || bus.o_opcode !== opc ||
            bus.o_state !== st || bus.o_valid !== v || bus.o_error !== er) begin
            failures++;
            $display("[TB] FAIL %s got op1=%0d op2=%0d opc=%h st=%0d v=%0b e=%0b required op1=%0d op2=%0d opc=%h st=%0d v=%0b e=%0b",
                     name, bus.o_op_1, bus.o_op_2, bus.o_opcode, bus.o_state, bus.o_valid, bus.o_error,
                     op1, op2, opc, st, v, er);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] mask, input logic signed [7:0] sw, input int hold, input int rel);
        @(posedge clk); #1;
        bus.i_switches   = sw;
        bus.i_pulsadores = mask;
        model_press(mask, sw, cycle);
        repeat (hold) @(posedge clk);
        #1 bus.i_pulsadores = '0;
        repeat (rel) @(posedge clk);
    endtask

    initial begin
        logic [3:0]        mask;
        logic signed [7:0] sw;
        int                r, b0, b1;
        int                bounce [5];
        bounce = '{1, 0, 1, 1, 0};

        bus.i_switches   = '0;
        bus.i_pulsadores = '0;
        repeat (3) @(posedge clk);
        #1 checkOutput("reset_values", 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1 checkOutput("idle_after_reset", 0, 0, 0, 0, 0, 0);

        applyStimulus(4'b0001, 8'sh05, 10, 12);
        applyStimulus(4'b0010, 8'shFD, 10, 12);
        applyStimulus(4'b0100, 8'sh21, 10, 12);
        #1 checkOutput("normal_sequence", 8'sd5, -8'sd3, 6'h21, 2'd3, 0, 0);

        @(posedge clk); #1 bus.i_switches = 8'sh11; bus.i_pulsadores = 4'b0001;
        repeat (3) @(posedge clk);
        #1 bus.i_pulsadores = '0;
        repeat (15) @(posedge clk);
        #1 checkOutput("glitch_ignored", 8'sd5, -8'sd3, 6'h21, 2'd3, 0, 0);

        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 bus.i_pulsadores = 4'(bounce[i]);
        end
        @(posedge clk); #1 bus.i_pulsadores = 4'b0001;
        model_press(4'b0001, 8'sh11, cycle);
        repeat (20) @(posedge clk);
        #1 bus.i_pulsadores = '0;
        repeat (12) @(posedge clk);
        #1 checkOutput("bounce_single_load", 8'sh11, -8'sd3, 6'h21, 2'd1, 0, 0);

        applyStimulus(4'b1000, 8'sh00, 10, 12);
        applyStimulus(4'b0100, 8'sh3F, 10, 12);
        #1 checkOutput("out_of_order_opcode", 0, 0, 0, 0, 0, 0);
        applyStimulus(4'b0011, 8'sh44, 10, 12);
        #1 checkOutput("double_press", 0, 0, 0, 0, 0, 0);

        applyStimulus(4'b0001, 8'sh0A, 10, 12);
        applyStimulus(4'b0010, 8'sh0B, 10, 12);
        applyStimulus(4'b0100, 8'sh0C, 10, 12);
        applyStimulus(4'b0010, 8'sh7F, 10, 12);
        #1 checkOutput("done_edit_b", 8'sh0A, 8'sd127, 6'h0C, 2'd3, 0, 0);
        applyStimulus(4'b1000, 8'sh55, 10, 12);
        #1 checkOutput("clear", 0, 0, 0, 0, 0, 0);

        applyStimulus(4'b0001, 8'sh22, 10, 12);
        @(posedge clk); #1 bus.i_switches = 8'sh33; bus.i_pulsadores = 4'b0010;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("async_reset_mid_debounce", 0, 0, 0, 0, 0, 0);
        exp_q.delete();
        m_state = 0; m_op1 = '0; m_op2 = '0; m_opc = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_press(4'b0010, 8'sh33, cycle);
        repeat (12) @(posedge clk);
        #1 bus.i_pulsadores = '0;
        repeat (12) @(posedge clk);

        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 99);
            sw = 8'($urandom);
            if (r < 12) begin
                b0 = $urandom_range(0, 3);
                b1 = (b0 + $urandom_range(1, 3)) % 4;
                mask = 4'((1 << b0) | (1 << b1));
            end else if (r < 20) begin
                mask = 4'b1000;
            end else begin
                mask = 4'(1 << $urandom_range(0, 2));
            end
            applyStimulus(mask, sw, 10, 12);
        end

        repeat (10) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL pending_events got %0d outstanding required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_input_sequencer.md
# alu_input_sequencer

Parametrised front-end for the Basys3 ALU: captures operand A, operand B and the opcode from the slide switches under pushbutton control. Each button is synchronised, debounced and edge-detected, so one physical press is exactly one load. A state machine enforces the A → B → opcode load order, pulses `o_valid` when a complete operation is present, and flags out-of-order or ambiguous presses. The outputs drive the `alu` instance's `i_op_1`, `i_op_2` and `i_opcode` inputs directly.

## Interface
- `NB_DATA`, 8, switch and operand width.
- `NB_OPCODE`, 6, opcode width; must satisfy NB_OPCODE ≤ NB_DATA.
- `N_PULSADORES`, 4, button count; must be ≥ 4. Button 0 = load A, 1 = load B, 2 = load opcode, 3 = clear; buttons ≥ 4 are ignored.
- `DEBOUNCE_CYCLES`, 1000000, consecutive stable cycles required to accept a level change; must be ≥ 2.
- `i_clock`  in  1  single clock for the block.
- `i_reset`  in  1  reset; asynchronous, active-high.
- `i_switches`  in  NB_DATA  signed switch value.
- `i_pulsadores`  in  N_PULSADORES  raw asynchronous pushbuttons, active-high.
- `o_op_1`  out  NB_DATA  signed operand A.
- `o_op_2`  out  NB_DATA  signed operand B.
- `o_opcode`  out  NB_OPCODE  opcode.
- `o_valid`  out  1  one-cycle pulse each time a complete operation is (re)loaded.
- `o_error`  out  1  one-cycle pulse when a press is rejected.
- `o_state`  out  2  current FSM state, intended for LEDs.

## Operation
- **Per button (0..3):**
  - 2-FF synchroniser.
  - Debounce counter: increments on each edge where the synchronised level ≠ debounced level, and clears whenever they are equal.
  - When the increment would reach DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change the debounced level.
- **Press pulse:** debounced level high AND its previous-cycle value low, lasting one cycle. Releases produce no pulse.
- **Multiple presses:** if more than one press pulse is active in the same cycle, all are discarded, `o_error` pulses, and no register or state changes.
- **FSM states** (`o_state` encoding):
  - WAIT_A = 0
  - WAIT_B = 1
  - WAIT_OPC = 2
  - DONE = 3
- **Transitions on a single press pulse:**
  - Clear (btn3), any state → WAIT_A. `o_op_1`, `o_op_2` and `o_opcode` are zeroed. No `o_valid`, no `o_error`.
  - WAIT_A + btn0: `o_op_1` ← `i_switches` → WAIT_B.
  - WAIT_B + btn1: `o_op_2` ← `i_switches` → WAIT_OPC.
  - WAIT_OPC + btn2: `o_opcode` ← `i_switches[NB_OPCODE-1:0]` → DONE, and `o_valid` pulses.
  - DONE + btn0: load A → WAIT_B (starts a new sequence; the old B and opcode are kept but not valid).
  - DONE + btn1 or btn2: reload that register, stay in DONE, `o_valid` pulses again (edit mode).
  - Any other button in WAIT_A, WAIT_B or WAIT_OPC: ignored, `o_error` pulses, registers unchanged.
- **Register hold:** registers hold their value whenever they are not loaded.
- **Switch sampling:** `i_switches` is sampled on the same edge the register updates. The switches are not synchronised, because they are quasi-static.

## Timing
- **Reset values:** all outputs are 0, state is WAIT_A, and synchronisers, debounced levels and counters are 0. Reset acts immediately and asynchronously, including mid-debounce or mid-sequence.
- **Load latency:** with a button rising before edge E1 and held, the debounced level rises at edge E(D+2). The target register, state, `o_valid` and `o_error` all update at edge E(D+3), where D = DEBOUNCE_CYCLES.
- **Output registration:** `o_valid` and `o_error` are registered outputs, high for exactly the one cycle after E(D+3).
- **Press rate:** holding a button generates one press only. A re-press requires a debounced release of ≥ D cycles followed by a new debounced press.
- **Button held through reset release:** the debounced level starts at 0, so the button is treated as a new press with the same D+3 latency counted from the first edge after reset deassertion.
- **Simultaneous press:** two buttons whose press pulses land on different cycles are processed independently in order. Pulses on the same cycle are handled by the multiple-press rule (error).

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and default widths.
- **Reset defaults:** assert `i_reset` → all outputs 0 and `o_state`=0 immediately. Deassert and idle for 20 cycles → no change.
- **Normal sequence:** switches 8'sh05 + btn0, then 8'shFD + btn1, then 8'h21 + btn2 (each held 10 cycles).
  - Each register updates exactly 7 edges after its button rises.
  - `o_op_1`=5, `o_op_2`=-3, `o_opcode`=6'h21.
  - `o_valid` is a single pulse and `o_state` ends at 3.
- **Debounce:** 3-cycle glitch on btn0 → no change. A bouncing pattern (1,0,1,1,0, then 20 cycles steady high) → exactly one load of A.
- **Out of order and multiple press:**
  - In WAIT_A, press btn2 → `o_error` pulses, opcode stays 0, state stays 0.
  - btn0 and btn1 pressed together → `o_error` pulses, no load.
- **DONE behaviour and clear:**
  - In DONE, btn1 with 8'sh7F → `o_op_2`=127, `o_valid` pulses, state stays 3.
  - Then btn3 → all registers 0, state 0, no `o_valid` or `o_error`.
- **Reset mid-operation:** assert `i_reset` during debounce of btn1 while in WAIT_B → immediate clear. With btn1 still held after release → no load of B and `o_error` pulses 7 edges later, because the state is WAIT_A.
